writeback_queue: RTL

//  Write-back stage directly upstream of the register bank: buffers register results from the ALU
//  and memory paths and drains them, one per cycle, into the bank's single write port.

---
 rtl/writeback_queue_pkg.sv | 16 +
 rtl/wbq_forward_select.sv | 38 +++
 rtl/writeback_queue.sv | 119 +++++++++++
 3 files changed

// File: rtl/writeback_queue_pkg.sv
// Processor-wide register-file defines shared by decode, the register bank
// and the write-back queue.
package writeback_queue_pkg;

  localparam int REGISTER_SIZE = 32;
  localparam int ADDRESS_SIZE  = 5;

  // r0 is hard-wired to zero: writes to it are dropped, reads never forward.
  localparam logic [ADDRESS_SIZE-1:0] ZERO_REG = '0;

  // True when a destination address names the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [ADDRESS_SIZE-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/wbq_forward_select.sv
// DEPTH-way destination compare over the occupied window head..head+count-1,
// returning the youngest matching entry (closest to the tail).
module wbq_forward_select
  import writeback_queue_pkg::*;
#(
  parameter int RS    = REGISTER_SIZE,
  parameter int AS    = ADDRESS_SIZE,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH*AS-1:0] entry_addr,
  input  logic [DEPTH*RS-1:0] entry_data,
  input  logic [PW-1:0]       head,
  input  logic [CW-1:0]       count,
  input  logic [AS-1:0]       lookup_addr,
  output logic                hit,
  output logic [RS-1:0]       data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so later (younger) matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (lookup_addr != AS'(ZERO_REG)) &&
          (entry_addr[idx*AS +: AS] == lookup_addr)) begin
        hit  = 1'b1;
        data = entry_data[idx*RS +: RS];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue in front of the register bank: accepts up to two results
// per cycle (memory first, then ALU), drains one per cycle into the bank's
// write port and forwards still-queued results to two decode read probes.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int REGISTER_SIZE = writeback_queue_pkg::REGISTER_SIZE,
  parameter int ADDRESS_SIZE  = writeback_queue_pkg::ADDRESS_SIZE,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [REGISTER_SIZE-1:0]     mem_data,
  input  logic [ADDRESS_SIZE-1:0]      mem_addr,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REGISTER_SIZE-1:0]     alu_data,
  input  logic [ADDRESS_SIZE-1:0]      alu_addr,
  output logic                         rf_write,
  output logic [REGISTER_SIZE-1:0]     rf_data_in,
  output logic [ADDRESS_SIZE-1:0]      rf_addr_in,
  input  logic [ADDRESS_SIZE-1:0]      lookup_addr1,
  input  logic [ADDRESS_SIZE-1:0]      lookup_addr2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [REGISTER_SIZE-1:0]     fwd_data1,
  output logic [REGISTER_SIZE-1:0]     fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int RS = REGISTER_SIZE;
  localparam int AS = ADDRESS_SIZE;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a result transfers on a rising edge where valid && ready are
  // both high. ready is computed from registered occupancy only (plus
  // mem_valid for the ALU port, since the older memory result claims space
  // first); no ready depends on its own valid, and the same-cycle pop is
  // never credited. A transfer to r0 completes but stores nothing.

  logic [DEPTH*AS-1:0] addr_q;
  logic [DEPTH*RS-1:0] data_q;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [PW-1:0]       alu_slot;
  logic [CW-1:0]       free;
  logic                mem_take;
  logic                mem_push;
  logic                alu_push;
  logic                pop;

  // Space accounting and push/pop decisions from registered state.
  always_comb begin
    free      = CW'(DEPTH) - count;
    mem_ready = (free >= CW'(1));
    mem_take  = mem_valid && mem_ready;
    alu_ready = (free >= (CW'(1) + CW'(mem_take)));
    mem_push  = mem_take && !is_zero_reg(mem_addr);
    alu_push  = alu_valid && alu_ready && !is_zero_reg(alu_addr);
    pop       = (count != '0);
    alu_slot  = tail + PW'(mem_push);
  end

  // Bank-side view of the head entry, masked to zero when empty.
  always_comb begin
    rf_write   = (count != '0);
    rf_addr_in = rf_write ? addr_q[head*AS +: AS] : '0;
    rf_data_in = rf_write ? data_q[head*RS +: RS] : '0;
  end

  // Pointer and occupancy state; reset clears it without touching storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail  <= tail + PW'(mem_push) + PW'(alu_push);
      count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  // Entry storage: memory result lands at the tail, ALU result just behind it.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      addr_q[tail*AS +: AS] <= mem_addr;
      data_q[tail*RS +: RS] <= mem_data;
    end
    if (alu_push) begin
      addr_q[alu_slot*AS +: AS] <= alu_addr;
      data_q[alu_slot*RS +: RS] <= alu_data;
    end
  end

  wbq_forward_select #(.RS(RS), .AS(AS), .DEPTH(DEPTH)) u_fwd1 (
    .entry_addr  (addr_q),
    .entry_data  (data_q),
    .head        (head),
    .count       (count),
    .lookup_addr (lookup_addr1),
    .hit         (fwd_hit1),
    .data        (fwd_data1)
  );

  wbq_forward_select #(.RS(RS), .AS(AS), .DEPTH(DEPTH)) u_fwd2 (
    .entry_addr  (addr_q),
    .entry_data  (data_q),
    .head        (head),
    .count       (count),
    .lookup_addr (lookup_addr2),
    .hit         (fwd_hit2),
    .data        (fwd_data2)
  );

endmodule
